// File: rtl/spm_seq.sv
// rtl/spm_seq.sv - operand/result sequencer in front of the serial-parallel multiplier
module spm_seq #(
    parameter int TIMEOUT_CYCLES = 128,
    parameter int TMR_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_mc,
    input  logic [31:0] in_mp,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] res_prod,
    output logic        res_err,
    output logic [31:0] spm_mc,
    output logic [31:0] spm_mp,
    output logic        spm_start,
    input  logic [63:0] spm_prod,
    input  logic        spm_done,
    output logic        busy,
    output logic [15:0] op_count
);

    typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q, state_d;
    logic               pend_valid_q, pend_valid_d;
    logic [31:0]        pend_mc_q, pend_mc_d;
    logic [31:0]        pend_mp_q, pend_mp_d;
    logic               res_valid_q, res_valid_d;
    logic [63:0]        res_prod_q, res_prod_d;
    logic               res_err_q, res_err_d;
    logic [31:0]        spm_mc_q, spm_mc_d;
    logic [31:0]        spm_mp_q, spm_mp_d;
    logic               spm_start_q, spm_start_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [15:0]        op_count_q, op_count_d;
    logic               launch;
    logic               accept;

    // A launch frees the pending entry in the same cycle, so it can be refilled at once.
    assign launch   = (state_q == IDLE) && pend_valid_q && (!res_valid_q || res_ready);
    assign in_ready = !pend_valid_q || launch;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_mc_d    = pend_mc_q;
        pend_mp_d    = pend_mp_q;
        res_valid_d  = res_valid_q;
        res_prod_d   = res_prod_q;
        res_err_d    = res_err_q;
        spm_mc_d     = spm_mc_q;
        spm_mp_d     = spm_mp_q;
        spm_start_d  = spm_start_q;
        timer_d      = timer_q;
        op_count_d   = op_count_q;

        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end

        if (accept) begin
            pend_valid_d = 1'b1;
            pend_mc_d    = in_mc;
            pend_mp_d    = in_mp;
        end

        case (state_q)
            IDLE: begin
                if (launch) begin
                    spm_mc_d    = pend_mc_q;
                    spm_mp_d    = pend_mp_q;
                    spm_start_d = 1'b1;
                    timer_d     = '0;
                    state_d     = START;
                    if (!accept) begin
                        pend_valid_d = 1'b0;
                    end
                end
            end
            START: begin
                spm_start_d = 1'b0;
                state_d     = BUSY;
            end
            BUSY: begin
                timer_d = timer_q + 1'b1;
                // Completion beats the timeout when both land on the same cycle.
                if (spm_done) begin
                    res_prod_d  = spm_prod;
                    res_err_d   = 1'b0;
                    res_valid_d = 1'b1;
                    op_count_d  = op_count_q + 16'd1;
                    state_d     = IDLE;
                end else if (timer_q == TMO_LAST) begin
                    res_prod_d  = '0;
                    res_err_d   = 1'b1;
                    res_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            pend_valid_q <= 1'b0;
            pend_mc_q    <= '0;
            pend_mp_q    <= '0;
            res_valid_q  <= 1'b0;
            res_prod_q   <= '0;
            res_err_q    <= 1'b0;
            spm_mc_q     <= '0;
            spm_mp_q     <= '0;
            spm_start_q  <= 1'b0;
            timer_q      <= '0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_mc_q    <= pend_mc_d;
            pend_mp_q    <= pend_mp_d;
            res_valid_q  <= res_valid_d;
            res_prod_q   <= res_prod_d;
            res_err_q    <= res_err_d;
            spm_mc_q     <= spm_mc_d;
            spm_mp_q     <= spm_mp_d;
            spm_start_q  <= spm_start_d;
            timer_q      <= timer_d;
            op_count_q   <= op_count_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_prod  = res_prod_q;
    assign res_err   = res_err_q;
    assign spm_mc    = spm_mc_q;
    assign spm_mp    = spm_mp_q;
    assign spm_start = spm_start_q;
    assign busy      = (state_q != IDLE);
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_spm_seq.sv
// tb/tb_spm_seq.sv - scoreboard bench for spm_seq with a behavioural multiplier model
module tb_spm_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_mc;
    logic [31:0] in_mp;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_prod;
    logic        res_err;
    logic [31:0] spm_mc;
    logic [31:0] spm_mp;
    logic        spm_start;
    logic [63:0] spm_prod = '0;
    logic        spm_done = 1'b0;
    logic        busy;
    logic [15:0] op_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        err;
        logic [63:0] prod;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    logic [63:0] last_prod = '0;
    logic        last_err  = 1'b0;

    int done_at       = 63;
    bit done_in_start = 1'b0;
    int m_cnt         = 0;
    bit m_active      = 1'b0;

    always #5 clk = ~clk;

    spm_seq #(.TIMEOUT_CYCLES(128), .TMR_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mc(in_mc), .in_mp(in_mp),
        .res_valid(res_valid), .res_ready(res_ready), .res_prod(res_prod), .res_err(res_err),
        .spm_mc(spm_mc), .spm_mp(spm_mp), .spm_start(spm_start),
        .spm_prod(spm_prod), .spm_done(spm_done),
        .busy(busy), .op_count(op_count)
    );

    // Multiplier model: done_at counts BUSY cycles from 0; -1 never completes.
    always @(negedge clk) begin
        spm_done = 1'b0;
        if (!rst) begin
            m_active = 1'b0;
            spm_prod = '0;
        end else if (spm_start) begin
            m_active = 1'b1;
            m_cnt    = 0;
            if (done_in_start) begin
                spm_done = 1'b1;
                spm_prod = 64'hDEAD_BEEF_0BAD_F00D;
            end
        end else if (m_active) begin
            if (m_cnt == done_at) begin
                spm_done = 1'b1;
                spm_prod = {32'h0, spm_mc} * {32'h0, spm_mp};
                m_active = 1'b0;
            end
            m_cnt++;
        end
    end

    always @(negedge clk) begin
        if (rst && res_valid && res_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL result_unexpected: got prod=%h err=%b, expected no result", res_prod, res_err);
            end else begin
                mon_e     = sb.pop_front();
                last_prod = res_prod;
                last_err  = res_err;
                if ({res_err, res_prod} !== mon_e) begin
                    errors++;
                    $display("FAIL result: got prod=%h err=%b, expected prod=%h err=%b",
                             res_prod, res_err, mon_e.prod, mon_e.err);
                end
            end
        end
    end

    task automatic send(input logic [31:0] mc, input logic [31:0] mp, input logic err);
        bit ok;
        int n;
        in_mc    = mc;
        in_mp    = mp;
        in_valid = 1'b1;
        n        = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 2000);
        in_valid = 1'b0;
        if (ok) begin
            if (err) sb.push_back({1'b1, 64'h0});
            else     sb.push_back({1'b0, {32'h0, mc} * {32'h0, mp}});
        end else begin
            checks++;
            errors++;
            $display("FAIL send_accept: in_ready never rose, expected accept within 2000 cycles");
        end
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; in_valid = 1'b0; in_mc = '0; in_mp = '0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
        checks++; if (res_prod !== 64'h0) begin errors++; $display("FAIL reset_res_prod: got %h expected 0", res_prod); end
        checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL reset_res_err: got %b expected 0", res_err); end
        checks++; if ({spm_mc, spm_mp} !== 64'h0) begin errors++; $display("FAIL reset_spm_ops: got %h expected 0", {spm_mc, spm_mp}); end
        checks++; if (spm_start !== 1'b0) begin errors++; $display("FAIL reset_spm_start: got %b expected 0", spm_start); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (op_count !== 16'h0) begin errors++; $display("FAIL reset_op_count: got %0d expected 0", op_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single;
        int starts = 0;
        int n = 0;
        done_at = 63; res_ready = 1'b1;
        send(32'd3, 32'd5, 1'b0);
        checks++; if (spm_start !== 1'b0) begin errors++; $display("FAIL single_start_early: got %b expected 0", spm_start); end
        @(posedge clk);
        #1;
        checks++; if (spm_start !== 1'b1) begin errors++; $display("FAIL single_start_latency: got %b expected 1", spm_start); end
        checks++; if ({spm_mc, spm_mp} !== {32'd3, 32'd5}) begin errors++; $display("FAIL single_spm_ops: got %h expected %h", {spm_mc, spm_mp}, {32'd3, 32'd5}); end
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            if (spm_start) starts++;
            n++;
        end
        checks++; if (starts != 1) begin errors++; $display("FAIL single_start_width: got %0d cycles expected 1", starts); end
        wait_drain(10);
        checks++; if (last_prod !== 64'h0F || last_err !== 1'b0) begin errors++; $display("FAIL single_prod: got %h/%b expected 000000000000000f/0", last_prod, last_err); end
        checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL single_op_count: got %0d expected 1", op_count); end
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle: got valid=%b busy=%b expected 0/0", res_valid, busy); end
    endtask

    task automatic test_max;
        done_at = 40;
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_drain(400);
        checks++; if (last_prod !== 64'hFFFF_FFFE_0000_0001 || last_err !== 1'b0) begin errors++; $display("FAIL max_prod: got %h/%b expected fffffffe00000001/0", last_prod, last_err); end
        checks++; if (op_count !== 16'd2) begin errors++; $display("FAIL max_op_count: got %0d expected 2", op_count); end
    endtask

    task automatic test_back_to_back;
        int n = 0;
        bit launched = 1'b0;
        done_at = 30; res_ready = 1'b0;
        send(32'd10, 32'd11, 1'b0);
        send(32'd12, 32'd13, 1'b0);
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_pend_full: got in_ready=%b busy=%b expected 0/1", in_ready, busy); end
        while (!res_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL b2b_first_result: got res_valid=%b expected 1", res_valid); end
        repeat (20) begin
            @(negedge clk);
            if (busy || spm_start) launched = 1'b1;
        end
        checks++; if (launched || in_ready !== 1'b0) begin errors++; $display("FAIL b2b_blocked: got launched=%b in_ready=%b expected 0/0", launched, in_ready); end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        send(32'd14, 32'd15, 1'b0);
        wait_drain(600);
        checks++; if (op_count !== 16'd5) begin errors++; $display("FAIL b2b_op_count: got %0d expected 5", op_count); end
    endtask

    task automatic test_timeout;
        int n = 0;
        done_at = -1; res_ready = 1'b1;
        send(32'd7, 32'd9, 1'b1);
        while (!spm_start && n < 10) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid && n < 400);
        checks++; if (n != 129) begin errors++; $display("FAIL timeout_cycles: got %0d busy cycles expected 128", n - 1); end
        wait_drain(10);
        checks++; if (op_count !== 16'd5) begin errors++; $display("FAIL timeout_op_count: got %0d expected 5", op_count); end
        done_at = 20;
        send(32'd2, 32'd3, 1'b0);
        wait_drain(300);
        checks++; if (op_count !== 16'd6) begin errors++; $display("FAIL timeout_recover: got %0d expected 6", op_count); end
    endtask

    task automatic test_reset_mid;
        bit seen = 1'b0;
        done_at = -1; res_ready = 1'b1;
        send(32'd4, 32'd4, 1'b0);
        send(32'd5, 32'd5, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_setup: got busy=%b in_ready=%b expected 1/0", busy, in_ready); end
        rst = 1'b0;
        #1;
        sb.delete();
        checks++; if (busy !== 1'b0 || res_valid !== 1'b0 || spm_start !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl: got busy=%b valid=%b start=%b expected 0/0/0", busy, res_valid, spm_start); end
        checks++; if ({spm_mc, spm_mp} !== 64'h0 || op_count !== 16'h0 || in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_data: got ops=%h cnt=%0d in_ready=%b expected 0/0/1", {spm_mc, spm_mp}, op_count, in_ready); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        done_at = 10;
        repeat (300) begin
            @(negedge clk);
            if (res_valid || busy) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL rstmid_spurious: got activity after release, expected none"); end
    endtask

    task automatic test_coincide;
        done_in_start = 1'b1; done_at = 127; res_ready = 1'b1;
        send(32'd6, 32'd7, 1'b0);
        wait_drain(500);
        done_in_start = 1'b0;
        checks++; if (last_prod !== 64'd42 || last_err !== 1'b0) begin errors++; $display("FAIL coincide_prod: got %h/%b expected 000000000000002a/0", last_prod, last_err); end
        checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL coincide_op_count: got %0d expected 1", op_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_max();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_coincide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spm_seq.md
Name: spm_seq

Overview:
- Command sequencer that sits directly upstream of the serial-parallel multiplier core (spm_top) and drives its operand, start and done interface.
- Accepts operand pairs over a valid/ready stream and buffers one pending pair.
- Launches one multiply at a time, waits for completion (with timeout), and returns the 64-bit product over a second valid/ready stream.
- Lets software or a DMA stream multiplies without polling done.

Parameters:
- TIMEOUT_CYCLES, 128: max BUSY cycles waiting for spm_done before abort (must be >= 2).
- TMR_W, 8: width of the timeout counter; must hold TIMEOUT_CYCLES-1.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset (rst=0 resets)
- in_valid  input  1  operand pair valid
- in_ready  output  1  pending buffer can accept
- in_mc  input  32  multiplicand
- in_mp  input  32  multiplier
- res_valid  output  1  result slot full
- res_ready  input  1  consumer takes result
- res_prod  output  64  product
- res_err  output  1  result was a timeout abort
- spm_mc  output  32  operand to multiplier, registered
- spm_mp  output  32  operand to multiplier, registered
- spm_start  output  1  start to multiplier, registered
- spm_prod  input  64  product from multiplier
- spm_done  input  1  completion from multiplier
- busy  output  1  state != IDLE
- op_count  output  16  count of successful multiplies

Behaviour:
- Reset (rst=0, async) clears everything:
  - state=IDLE; pend_valid=0.
  - res_valid=0, res_prod=0, res_err=0.
  - spm_mc=0, spm_mp=0, spm_start=0.
  - timer=0, op_count=0; busy=0.
- Pending buffer (1 entry):
  - in_ready = !pend_valid || launch (launch is combinational, defined below).
  - Handshake when in_valid && in_ready: capture in_mc/in_mp; pend_valid=1.
  - A simultaneous launch and accept is legal: old entry goes to the spm regs, new entry goes to pend.
- launch = (state==IDLE) && pend_valid && (!res_valid || res_ready). Only one multiply is ever in flight.
- States: IDLE, START, BUSY.
- IDLE:
  - On launch: spm_mc/spm_mp <= pend contents; spm_start <= 1; pend_valid <= 0 unless refilled the same cycle; timer <= 0; state -> START.
- START (exactly 1 cycle):
  - spm_start is 1 in this cycle.
  - spm_done is ignored here.
  - Next edge: spm_start <= 0, state -> BUSY.
- BUSY:
  - spm_mc/spm_mp are held stable.
  - timer increments by 1 per cycle.
  - If spm_done==1: res_prod <= spm_prod; res_err <= 0; res_valid <= 1; op_count <= op_count+1 (wraps 0xFFFF->0); state -> IDLE.
  - Else if timer == TIMEOUT_CYCLES-1: res_prod <= 0; res_err <= 1; res_valid <= 1; op_count unchanged; state -> IDLE.
  - If done and timeout occur in the same cycle, done wins.
- Result slot:
  - res_valid clears on res_valid && res_ready, unless it is refilled the same edge. A refill cannot happen in that cycle by construction, because launch requires a free slot.
  - res_prod and res_err stay stable while res_valid=1 && !res_ready.
- Latency:
  - in handshake at edge N -> earliest spm_start high in cycle after edge N+1.
  - spm_done sampled high at edge M -> res_valid high after edge M.
- Back-to-back: the next launch can occur in the first IDLE cycle after a result is written, provided the consumer has taken the previous result or res_ready=1 that cycle.
- Reset mid-operation: the in-flight op, pending op and unconsumed result are all discarded. No spurious res_valid after reset release. spm_top shares rst and restarts cleanly.

Test Plan:
- Reset, then in_mc=3, in_mp=5, res_ready=1; model spm_done 64 cycles after start with spm_prod=15 -> spm_start high exactly one cycle; res_prod=0x0F, res_err=0, op_count=1.
- in_mc=in_mp=0xFFFFFFFF -> res_prod=0xFFFFFFFE00000001, res_err=0.
- Stream 3 pairs back-to-back with res_ready held 0 after the first result:
  - in_ready drops once pend is full; no second launch until res_ready=1.
  - Results arrive in order; op_count=3.
- Multiplier model never asserts done, TIMEOUT_CYCLES=128 -> res_valid 128 BUSY cycles after START; res_prod=0, res_err=1; op_count unchanged; the next op still succeeds.
- Assert rst=0 during BUSY with one pending and one unconsumed result -> all outputs at reset values immediately; after release, no res_valid until a new operand pair completes.
- spm_done pulsed during START plus timeout coinciding with done in BUSY -> done in START ignored; done wins at the coincidence (res_err=0).
